// File: rtl/global_control.sv
// global_control: central sequencer that owns the global PC and call-stack
// pointer. It also keeps a LIFO of forward reconvergence targets for cores
// that have branched away from the global PC.
module global_control #(
    parameter int CORE_COUNT    = 16,
    parameter int CALL_DEPTH    = 8,
    parameter int PENDING_DEPTH = 8,
    parameter int PC_W          = 8,
    parameter int SP_W          = 4,
    parameter int IMM_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  instr_valid,
    input  logic [IMM_W-1:0]      immediate,
    input  logic                  is_cond_branch,
    input  logic                  is_uncond_branch,
    input  logic                  is_call,
    input  logic                  is_return,
    input  logic                  is_halt,
    input  logic [CORE_COUNT-1:0] diverge_vec,
    output logic [PC_W-1:0]       program_counter,
    output logic [PC_W-1:0]       next_program_counter,
    output logic [SP_W-1:0]       next_stack_pointer,
    output logic                  global_enable,
    output logic                  halted,
    output logic                  fault
);
    localparam int RI_W = (CALL_DEPTH > 1) ? $clog2(CALL_DEPTH) : 1;
    localparam int PI_W = (PENDING_DEPTH > 1) ? $clog2(PENDING_DEPTH) : 1;
    localparam int LC_W = $clog2(PENDING_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [LC_W-1:0] lcnt_q, lcnt_d;
    logic            halted_q, fault_q;

    logic [PC_W-1:0] ras_q      [CALL_DEPTH];
    logic [PC_W-1:0] pend_tgt_q [PENDING_DEPTH];
    logic [SP_W-1:0] pend_sp_q  [PENDING_DEPTH];

    logic            ras_push, pend_push, go_fault;
    logic [PC_W-1:0] imm, pc_inc, top_tgt;
    logic [SP_W-1:0] top_sp;
    logic [RI_W-1:0] ras_wr_idx, ras_rd_idx;
    logic [PI_W-1:0] top_idx, push_idx;
    logic            pend_empty, pend_full, div_all, div_any;
    logic            unused_imm_hi;

    // Upper immediate bits are intentionally dropped: targets are PC-wide.
    assign imm           = immediate[PC_W-1:0];
    assign unused_imm_hi = ^immediate[IMM_W-1:PC_W];

    assign pc_inc     = pc_q + 1'b1;
    assign ras_wr_idx = RI_W'(sp_q);
    assign ras_rd_idx = RI_W'(sp_q - 1'b1);
    assign top_idx    = PI_W'(lcnt_q - 1'b1);
    assign push_idx   = PI_W'(lcnt_q);
    assign top_tgt    = pend_tgt_q[top_idx];
    assign top_sp     = pend_sp_q[top_idx];
    assign pend_empty = (lcnt_q == '0);
    assign pend_full  = (lcnt_q == LC_W'(PENDING_DEPTH));
    assign div_all    = &diverge_vec;
    assign div_any    = |diverge_vec;

    assign global_enable        = (state_q == RUN) && instr_valid;
    assign program_counter      = pc_q;
    assign next_program_counter = pc_d;
    assign next_stack_pointer   = sp_d;
    assign halted               = halted_q;
    assign fault                = fault_q;

    // Next PC/SP, state and stack operations from the decoded instruction.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        lcnt_d    = lcnt_q;
        ras_push  = 1'b0;
        pend_push = 1'b0;
        go_fault  = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: if (instr_valid) begin
                if (is_halt) begin
                    state_d = HALTED;
                end else if (is_call) begin
                    if (sp_q == SP_W'(CALL_DEPTH)) go_fault = 1'b1;
                    else begin
                        ras_push = 1'b1;
                        sp_d     = sp_q + 1'b1;
                        pc_d     = imm;
                    end
                end else if (is_return) begin
                    if (sp_q == '0) go_fault = 1'b1;
                    else begin
                        sp_d = sp_q - 1'b1;
                        pc_d = ras_q[ras_rd_idx];
                    end
                end else if (is_uncond_branch) begin
                    pc_d = imm;
                end else if (is_cond_branch && div_all) begin
                    // Whole array jumps; must not overshoot a pending rejoin point.
                    if (pend_empty || imm <= top_tgt) pc_d = imm;
                    else go_fault = 1'b1;
                end else if (is_cond_branch && div_any) begin
                    // Stragglers continue at PC+1; the branchers wait at imm.
                    pc_d = pc_inc;
                    if (imm <= pc_q) go_fault = 1'b1;
                    else if (pend_empty) pend_push = 1'b1;
                    else if (imm < top_tgt) begin
                        if (pend_full) go_fault = 1'b1;
                        else pend_push = 1'b1;
                    end else if (imm > top_tgt) go_fault = 1'b1;
                end else begin
                    pc_d = pc_inc;
                end

                if (go_fault) begin
                    pc_d      = pc_q;
                    sp_d      = sp_q;
                    ras_push  = 1'b0;
                    pend_push = 1'b0;
                    state_d   = FAULT;
                end else if (pend_push) begin
                    lcnt_d = lcnt_q + 1'b1;
                end else if (!pend_empty && pc_d == top_tgt && sp_d == top_sp) begin
                    // A push only happens below the old top, so push and pop never coincide.
                    lcnt_d = lcnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State machine, PC/SP and stack depth with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            sp_q     <= '0;
            lcnt_q   <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            lcnt_q   <= lcnt_d;
            halted_q <= (state_d == HALTED);
            fault_q  <= (state_d == FAULT);
        end
    end

    // Stack storage; contents are don't-care above the current depth.
    always_ff @(posedge clk) begin
        if (ras_push) ras_q[ras_wr_idx] <= pc_inc;
        if (pend_push) begin
            pend_tgt_q[push_idx] <= imm;
            pend_sp_q[push_idx]  <= sp_q;
        end
    end
endmodule

// File: tb/tb_global_control.sv
// tb_global_control: directed and random stimulus against a queue-based model.
module tb_global_control;
    localparam int CC = 16, CD = 8, PD = 8, PC_W = 8, SP_W = 4, IMM_W = 16;
    localparam int PCM = 1 << PC_W;
    localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_FAULT = 3;
    localparam int K_NONE = 0, K_COND = 1, K_UNC = 2, K_CALL = 3, K_RET = 4, K_HALT = 5;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, instr_valid = 1'b0;
    logic [IMM_W-1:0] immediate = '0;
    logic is_cond_branch = 1'b0, is_uncond_branch = 1'b0, is_call = 1'b0;
    logic is_return = 1'b0, is_halt = 1'b0;
    logic [CC-1:0] diverge_vec = '0;
    logic [PC_W-1:0] program_counter, next_program_counter;
    logic [SP_W-1:0] next_stack_pointer;
    logic global_enable, halted, fault;

    global_control #(.CORE_COUNT(CC), .CALL_DEPTH(CD), .PENDING_DEPTH(PD),
                     .PC_W(PC_W), .SP_W(SP_W), .IMM_W(IMM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .instr_valid(instr_valid),
        .immediate(immediate), .is_cond_branch(is_cond_branch),
        .is_uncond_branch(is_uncond_branch), .is_call(is_call),
        .is_return(is_return), .is_halt(is_halt), .diverge_vec(diverge_vec),
        .program_counter(program_counter), .next_program_counter(next_program_counter),
        .next_stack_pointer(next_stack_pointer), .global_enable(global_enable),
        .halted(halted), .fault(fault));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: return stack and pending targets as plain queues.
    typedef struct { int tgt; int sp; } pend_t;
    int    m_pc = 0, m_st = S_IDLE;
    bit    m_valid = 1'b0;
    int    m_ras[$];
    pend_t m_pend[$];
    int    n_pc = 0, n_st = S_IDLE;
    bit    n_valid = 1'b0;
    int    n_ras[$];
    pend_t n_pend[$];

    always @(negedge clk) begin : model_cmp
        int e_npc, e_nsp, im, pcp1, top;
        bit en, flt, pushed, d_all, d_any;
        pend_t p;
        if (!rst) begin
            n_valid = 1'b1; n_pc = 0; n_st = S_IDLE;
            n_ras.delete(); n_pend.delete();
        end else if (m_valid) begin
            n_ras = m_ras; n_pend = m_pend; n_st = m_st;
            en    = (m_st == S_RUN) && instr_valid;
            e_npc = m_pc; e_nsp = m_ras.size();
            flt = 1'b0; pushed = 1'b0;
            im    = int'(immediate) % PCM;
            pcp1  = (m_pc + 1) % PCM;
            d_all = (diverge_vec == {CC{1'b1}});
            d_any = (diverge_vec != '0);
            top   = (m_pend.size() > 0) ? m_pend[m_pend.size()-1].tgt : 0;
            if (m_st == S_IDLE && start) n_st = S_RUN;
            if (en) begin
                if (is_halt) n_st = S_HALT;
                else if (is_call) begin
                    if (m_ras.size() == CD) flt = 1'b1;
                    else begin n_ras.push_back(pcp1); e_npc = im; end
                end else if (is_return) begin
                    if (m_ras.size() == 0) flt = 1'b1;
                    else e_npc = n_ras.pop_back();
                end else if (is_uncond_branch) e_npc = im;
                else if (is_cond_branch && d_all) begin
                    if (m_pend.size() == 0 || im <= top) e_npc = im;
                    else flt = 1'b1;
                end else if (is_cond_branch && d_any) begin
                    e_npc = pcp1;
                    if (im <= m_pc) flt = 1'b1;
                    else if (m_pend.size() == 0 || im < top) begin
                        if (m_pend.size() == PD) flt = 1'b1;
                        else begin
                            p.tgt = im; p.sp = m_ras.size();
                            n_pend.push_back(p); pushed = 1'b1;
                        end
                    end else if (im > top) flt = 1'b1;
                end else e_npc = pcp1;

                if (flt) begin
                    e_npc = m_pc; n_st = S_FAULT; n_ras = m_ras; n_pend = m_pend;
                end else begin
                    e_nsp = n_ras.size();
                    if (!pushed && m_pend.size() > 0 && e_npc == top &&
                        e_nsp == m_pend[m_pend.size()-1].sp)
                        void'(n_pend.pop_back());
                end
            end
            n_pc = e_npc;
            chk("pc", program_counter, m_pc);
            chk("next_pc", next_program_counter, e_npc);
            chk("next_sp", next_stack_pointer, e_nsp);
            chk("global_enable", global_enable, en);
            chk("halted", halted, m_st == S_HALT);
            chk("fault", fault, m_st == S_FAULT);
        end
    end

    always @(posedge clk) begin
        m_valid = n_valid; m_pc = n_pc; m_st = n_st;
        m_ras = n_ras; m_pend = n_pend;
    end

    task automatic apply(input bit r, input bit s, input bit v, input logic [IMM_W-1:0] imm,
                         input logic [4:0] fl, input logic [CC-1:0] dv);
        rst = r; start = s; instr_valid = v; immediate = imm;
        {is_halt, is_return, is_call, is_uncond_branch, is_cond_branch} = fl;
        diverge_vec = dv;
    endtask

    task automatic drive(input bit r, input bit s, input bit v, input logic [IMM_W-1:0] imm,
                         input logic [4:0] fl, input logic [CC-1:0] dv);
        @(posedge clk); #1;
        apply(r, s, v, imm, fl, dv);
        @(negedge clk);
    endtask

    task automatic op(input int kind, input int imm, input logic [CC-1:0] dv);
        logic [4:0] fl;
        fl = (kind == K_NONE) ? 5'd0 : 5'(1 << (kind - 1));
        drive(1'b1, 1'b0, 1'b1, IMM_W'(imm), fl, dv);
    endtask

    task automatic idle_cyc(input bit r, input bit s);
        drive(r, s, 1'b0, '0, '0, '0);
    endtask

    task automatic restart();
        idle_cyc(1'b0, 1'b0);
        idle_cyc(1'b1, 1'b1);
    endtask

    task automatic rnd_cycle();
        logic [4:0] fl;
        logic [CC-1:0] dv;
        logic [7:0] hi, lo;
        int r, tgt;
        bit v, s;
        @(posedge clk); #1;
        v  = ($urandom_range(0, 99) < 85);
        s  = ($urandom_range(0, 99) < 5);
        fl = '0;
        dv = CC'($urandom);
        tgt = $urandom_range(0, PCM - 1);
        r  = $urandom_range(0, 99);
        if (r < 2) fl[4] = 1'b1;
        else if (r < 12) fl[2] = 1'b1;
        else if (r < 20) begin
            if (m_ras.size() > 0 || $urandom_range(0, 9) == 0) fl[3] = 1'b1;
        end else if (r < 26) fl[1] = 1'b1;
        else if (r < 65) begin
            fl[0] = 1'b1;
            case ($urandom_range(0, 2))
                0: dv = '0;
                1: dv = '1;
                default: if (dv == '0 || dv == '1) dv = 16'h0F0F;
            endcase
            if ($urandom_range(0, 9) != 0) tgt = (m_pc + 2 + $urandom_range(0, 8)) % PCM;
        end
        if ($urandom_range(0, 9) == 0) fl[$urandom_range(0, 4)] = 1'b1;
        // A partial branch to PC+1 would rejoin in the same cycle it is recorded.
        if (fl[0] && tgt == (m_pc + 1) % PCM) tgt = (tgt + 1) % PCM;
        hi = 8'($urandom);
        lo = 8'(tgt);
        apply(1'b1, s, v, {hi, lo}, fl, dv);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_pc", program_counter, 0);
        chk("reset_halted", halted, 0);
        chk("reset_fault", fault, 0);

        // Start and straight-line execution.
        idle_cyc(1'b1, 1'b1);
        chk("idle_enable", global_enable, 0);
        op(K_NONE, 0, '0);
        chk("run_pc0", program_counter, 0);
        chk("run_enable", global_enable, 1);
        for (int i = 1; i < 4; i++) begin
            op(K_NONE, 0, '0);
            chk("seq_pc", program_counter, i);
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        chk("stall_pc", program_counter, 4);
        chk("stall_enable", global_enable, 0);
        chk("stall_npc", next_program_counter, 4);

        // Partial divergence records (9,0), popped when PC goes 8 -> 9.
        op(K_COND, 9, 16'h00F0);
        chk("partial_npc", next_program_counter, 5);
        op(K_NONE, 0, '0);
        chk("partial_pc", program_counter, 5);
        chk("pend_size1", m_pend.size(), 1);
        chk("pend_tgt", m_pend[0].tgt, 9);
        chk("pend_sp", m_pend[0].sp, 0);
        op(K_NONE, 0, '0);
        op(K_NONE, 0, '0);
        op(K_NONE, 0, '0);
        chk("rejoin_npc", next_program_counter, 9);
        op(K_UNC, 4, '0);
        chk("rejoin_pc", program_counter, 9);
        chk("pend_popped", m_pend.size(), 0);

        // Full divergence, then full divergence past a pending (7,0).
        op(K_COND, 9, 16'hFFFF);
        chk("full_npc", next_program_counter, 9);
        chk("full_pend", m_pend.size(), 0);
        op(K_UNC, 3, '0);
        op(K_COND, 7, 16'h0F00);
        chk("push7_npc", next_program_counter, 4);
        op(K_COND, 9, 16'hFFFF);
        chk("pend_top7", m_pend[0].tgt, 7);
        chk("overshoot_npc", next_program_counter, 4);
        op(K_NONE, 0, '0);
        chk("overshoot_fault", fault, 1);
        chk("overshoot_enable", global_enable, 0);
        chk("overshoot_halted", halted, 0);

        // Call / return / underflow.
        restart();
        chk("restart_pc", program_counter, 0);
        chk("restart_fault", fault, 0);
        repeat (3) op(K_NONE, 0, '0);
        op(K_CALL, 20, '0);
        chk("call_npc", next_program_counter, 20);
        chk("call_nsp", next_stack_pointer, 1);
        repeat (5) op(K_NONE, 0, '0);
        op(K_RET, 0, '0);
        chk("ret_pc", program_counter, 25);
        chk("ret_npc", next_program_counter, 4);
        chk("ret_nsp", next_stack_pointer, 0);
        op(K_RET, 0, '0);
        op(K_NONE, 0, '0);
        chk("underflow_fault", fault, 1);

        // Return-stack overflow on the ninth nested call.
        restart();
        for (int i = 0; i <= CD; i++) begin
            op(K_CALL, 10 + 2 * i, '0);
            if (i == CD - 1) chk("deep_nsp", next_stack_pointer, CD);
        end
        chk("overflow_npc", next_program_counter, 24);
        chk("overflow_nsp", next_stack_pointer, CD);
        op(K_NONE, 0, '0);
        chk("overflow_fault", fault, 1);

        // PC wrap, immediate truncation, backward partial divergence.
        restart();
        op(K_UNC, 255, '0);
        op(K_NONE, 0, '0);
        chk("wrap_npc", next_program_counter, 0);
        op(K_UNC, 16'hAB0A, '0);
        chk("trunc_npc", next_program_counter, 10);
        op(K_COND, 2, 16'h0001);
        chk("backward_npc", next_program_counter, 10);
        op(K_NONE, 0, '0);
        chk("backward_fault", fault, 1);

        // Halt, start ignored, reset leaves HALTED.
        restart();
        op(K_UNC, 6, '0);
        op(K_HALT, 0, '0);
        chk("halt_npc", next_program_counter, 6);
        idle_cyc(1'b1, 1'b1);
        chk("halted", halted, 1);
        chk("halted_nofault", fault, 0);
        chk("halted_pc", program_counter, 6);
        op(K_NONE, 0, '0);
        chk("halted_hold_pc", program_counter, 6);
        chk("halted_enable", global_enable, 0);
        idle_cyc(1'b0, 1'b0);
        idle_cyc(1'b1, 1'b0);
        chk("halt_reset_pc", program_counter, 0);
        chk("halt_reset_halted", halted, 0);

        // Random episodes, each beginning from reset.
        for (int ep = 0; ep < 40; ep++) begin
            restart();
            repeat (60) rnd_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
